// File: rtl/parity_frame_checker_if.sv
// Word stream into the parity/frame checker and the registered results it returns.
// The checker connects through the slave modport and the word source through the master modport.
interface parity_frame_checker_if #(
  parameter int WIDTH = 9,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_par;
  logic             in_last;
  logic             odd_sel;
  logic             out_valid;
  logic             pe;
  logic             po;
  logic             word_err;
  logic             frame_done;
  logic             frame_err;
  logic [WIDTH-1:0] col_par;
  logic [CNT_W-1:0] err_count;
  logic             busy;

  modport master (
    output in_valid, in_data, in_par, in_last, odd_sel,
    input  out_valid, pe, po, word_err, frame_done, frame_err, col_par, err_count, busy
  );

  modport slave (
    input  in_valid, in_data, in_par, in_last, odd_sel,
    output out_valid, pe, po, word_err, frame_done, frame_err, col_par, err_count, busy
  );
endinterface

// File: rtl/parity_frame_checker.sv
// Per-word parity check plus a column-parity frame check word, with a saturating error count.
// state | meaning
// IDLE  | no frame open; col_par is zero
// FRAME | at least one non-last word accepted; col_par holds the running column XOR
module parity_frame_checker #(
  parameter int WIDTH = 9,
  parameter int CNT_W = 8
) (
  input logic                    clk,
  input logic                    clear,
  input logic                    enable,
  parity_frame_checker_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, FRAME = 1'b1} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] col_par_q, col_par_next, col_base;
  logic [CNT_W-1:0] err_count_q, err_count_next;
  logic [CNT_W:0]   err_sum;
  logic [1:0]       err_inc;
  logic             accept;
  logic             word_err_next, frame_err_next;
  logic             pe_q, po_q, word_err_q, frame_err_q, out_valid_q, frame_done_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= IDLE;
    end else if (enable) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    col_par_next   = col_par_q;
    err_inc        = 2'b00;
    accept         = enable & bus.in_valid;
    // A single-word frame checks against all zeros rather than a stale column.
    col_base       = (state == FRAME) ? col_par_q : '0;
    word_err_next  = (^{bus.in_data, bus.in_par}) != bus.odd_sel;
    frame_err_next = |(col_base ^ bus.in_data);
    if (accept) begin
      err_inc = {1'b0, word_err_next} + {1'b0, bus.in_last & frame_err_next};
      if (bus.in_last) begin
        state_next   = IDLE;
        col_par_next = '0;
      end else begin
        state_next   = FRAME;
        col_par_next = col_base ^ bus.in_data;
      end
    end
    err_sum        = {1'b0, err_count_q} + {{(CNT_W-1){1'b0}}, err_inc};
    err_count_next = err_sum[CNT_W] ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      col_par_q    <= '0;
      err_count_q  <= '0;
      pe_q         <= 1'b0;
      po_q         <= 1'b0;
      word_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else if (enable) begin
      out_valid_q  <= bus.in_valid;
      frame_done_q <= bus.in_valid & bus.in_last;
      if (bus.in_valid) begin
        pe_q        <= ~^bus.in_data;
        po_q        <= ^bus.in_data;
        word_err_q  <= word_err_next;
        col_par_q   <= col_par_next;
        err_count_q <= err_count_next;
        if (bus.in_last) begin
          frame_err_q <= frame_err_next;
        end
      end
    end else begin
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.pe         = pe_q;
  assign bus.po         = po_q;
  assign bus.word_err   = word_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.col_par    = col_par_q;
  assign bus.err_count  = err_count_q;
  assign bus.busy       = (state == FRAME);

endmodule

// File: tb/tb_parity_frame_checker.sv
// Drives one word stream into two checkers (8-bit and 2-bit error counters) and
// compares both against a behavioural model with a scoreboard of per-word results.
module tb_parity_frame_checker;

  logic clk = 1'b0;
  logic clear;
  logic enable;
  always #5 clk = ~clk;

  parity_frame_checker_if #(.WIDTH(9), .CNT_W(8)) bus_a ();
  parity_frame_checker_if #(.WIDTH(9), .CNT_W(2)) bus_b ();

  parity_frame_checker #(.WIDTH(9), .CNT_W(8)) dut_a (
    .clk(clk), .clear(clear), .enable(enable), .bus(bus_a)
  );
  parity_frame_checker #(.WIDTH(9), .CNT_W(2)) dut_b (
    .clk(clk), .clear(clear), .enable(enable), .bus(bus_b)
  );

  typedef struct {
    logic       pe;
    logic       po;
    logic       we;
    logic       fd;
    logic       fe;
    logic [7:0] c8;
    logic [1:0] c2;
  } res_t;

  res_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  logic       m_frame, m_ov, m_fd, m_pe, m_po, m_we, m_fe;
  logic [8:0] m_col;
  int         m_c8, m_c2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic clr, input logic en, input logic vld,
                      input logic [8:0] d, input logic p, input logic lst, input logic od);
    res_t r;
    int   inc;
    logic we, fe;
    clear  = clr;
    enable = en;
    bus_a.in_valid = vld; bus_a.in_data = d; bus_a.in_par = p; bus_a.in_last = lst; bus_a.odd_sel = od;
    bus_b.in_valid = vld; bus_b.in_data = d; bus_b.in_par = p; bus_b.in_last = lst; bus_b.odd_sel = od;
    if (clr) begin
      m_frame = 0; m_col = '0; m_c8 = 0; m_c2 = 0;
      m_pe = 0; m_po = 0; m_we = 0; m_fe = 0; m_ov = 0; m_fd = 0;
    end else if (en) begin
      m_ov = vld;
      m_fd = vld & lst;
      if (vld) begin
        we  = ((^d) ^ p) != od;
        inc = int'(we);
        m_pe = ~^d;
        m_po = ^d;
        m_we = we;
        if (lst) begin
          fe = |((m_frame ? m_col : 9'h000) ^ d);
          m_fe = fe;
          inc += int'(fe);
          m_col = '0;
          m_frame = 0;
        end else begin
          m_col = m_frame ? (m_col ^ d) : d;
          m_frame = 1;
        end
        m_c8 = (m_c8 + inc > 255) ? 255 : m_c8 + inc;
        m_c2 = (m_c2 + inc > 3) ? 3 : m_c2 + inc;
        r.pe = m_pe; r.po = m_po; r.we = m_we; r.fd = lst; r.fe = m_fe;
        r.c8 = 8'(m_c8); r.c2 = 2'(m_c2);
        sb.push_back(r);
      end
    end else begin
      m_ov = 0;
      m_fd = 0;
    end
    @(posedge clk);
    #1;
    chk("out_valid_a", 32'(bus_a.out_valid), 32'(m_ov));
    chk("out_valid_b", 32'(bus_b.out_valid), 32'(m_ov));
    chk("frame_done", 32'(bus_a.frame_done), 32'(m_fd));
    chk("busy", 32'(bus_a.busy), 32'(m_frame));
    chk("col_par", 32'(bus_a.col_par), 32'(m_col));
    chk("hold_pe_po", 32'({bus_a.pe, bus_a.po}), 32'({m_pe, m_po}));
    chk("hold_errs", 32'({bus_a.word_err, bus_a.frame_err}), 32'({m_we, m_fe}));
    chk("err_count_a", 32'(bus_a.err_count), 32'(m_c8));
    chk("err_count_b", 32'(bus_b.err_count), 32'(m_c2));
    if (bus_a.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_result", 32'(bus_a.out_valid), 32'd0);
      end else begin
        r = sb.pop_front();
        chk("sb_pe", 32'(bus_a.pe), 32'(r.pe));
        chk("sb_po", 32'(bus_a.po), 32'(r.po));
        chk("sb_word_err", 32'(bus_a.word_err), 32'(r.we));
        chk("sb_frame_done", 32'(bus_a.frame_done), 32'(r.fd));
        if (r.fd) chk("sb_frame_err", 32'(bus_a.frame_err), 32'(r.fe));
        chk("sb_cnt8", 32'(bus_a.err_count), 32'(r.c8));
        chk("sb_cnt2", 32'(bus_b.err_count), 32'(r.c2));
      end
    end
  endtask

  initial begin
    m_frame = 0; m_col = '0; m_c8 = 0; m_c2 = 0;
    m_pe = 0; m_po = 0; m_we = 0; m_fe = 0; m_ov = 0; m_fd = 0;
    #1;
    // clr en vld data par last odd
    step(1, 1, 0, 9'h000, 0, 0, 0);
    step(1, 1, 0, 9'h000, 0, 0, 0);
    // single-word frame of zeros, even mode
    step(0, 1, 1, 9'h000, 0, 1, 0);
    step(0, 1, 0, 9'h000, 0, 0, 0);
    // bad parity, opens a frame
    step(0, 1, 1, 9'h1FF, 0, 0, 0);
    chk("req35_cnt", 32'(bus_a.err_count), 32'd1);
    chk("req35_col", 32'(bus_a.col_par), 32'h1FF);
    step(0, 1, 1, 9'h1FF, 1, 1, 0);
    // good frame then bad column frame
    step(0, 1, 1, 9'h003, 0, 0, 0);
    step(0, 1, 1, 9'h005, 0, 0, 0);
    step(0, 1, 1, 9'h006, 0, 1, 0);
    chk("req36_fe0", 32'(bus_a.frame_err), 32'd0);
    step(0, 1, 1, 9'h003, 0, 0, 0);
    step(0, 1, 1, 9'h005, 0, 0, 0);
    step(0, 1, 1, 9'h007, 1, 1, 0);
    chk("req36_fe1", 32'(bus_a.frame_err), 32'd1);
    chk("req36_cnt", 32'(bus_a.err_count), 32'd2);
    // odd parity mode words
    step(0, 1, 1, 9'h0AA, 1, 0, 1);
    step(0, 1, 1, 9'h0AA, 0, 1, 1);
    step(0, 1, 0, 9'h000, 0, 0, 0);
    // saturation on the 2-bit counter
    step(1, 1, 0, 9'h000, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 9'h001, 0, 0, 0);
    step(0, 1, 1, 9'h000, 1, 1, 0);
    chk("req37_sat", 32'(bus_b.err_count), 32'd3);
    // abort a frame with clear, word in the clear cycle is dropped
    step(0, 1, 1, 9'h003, 0, 0, 0);
    step(0, 1, 1, 9'h005, 0, 0, 0);
    step(1, 1, 1, 9'h1FF, 0, 1, 0);
    chk("req38_busy", 32'(bus_a.busy), 32'd0);
    step(0, 1, 1, 9'h000, 0, 1, 0);
    chk("req38_fe", 32'(bus_a.frame_err), 32'd0);
    // freeze with enable low mid-frame
    step(0, 1, 1, 9'h1FF, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 9'h0F0, 1, 1, 1);
    step(0, 1, 1, 9'h1FF, 1, 1, 0);
    // clear wins with enable low
    step(0, 1, 1, 9'h011, 0, 0, 0);
    step(1, 0, 1, 9'h011, 0, 0, 0);
    step(0, 1, 0, 9'h000, 0, 0, 0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/parity_frame_checker.md
PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 9, data word width in bits (WIDTH >= 2).
REQ-002 SHALL have parameter CNT_W, default 8, error-counter width in bits (CNT_W >= 2).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port clear  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port enable  input  1  global enable; low freezes all state.
REQ-006 SHALL have port in_valid  input  1  in_data, in_par and in_last are valid this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  data word.
REQ-008 SHALL have port in_par  input  1  transmitted parity bit for in_data.
REQ-009 SHALL have port in_last  input  1  word is the frame check word (column-parity word).
REQ-010 SHALL have port odd_sel  input  1  0 = even parity scheme, 1 = odd parity scheme; sampled per accepted word.
REQ-011 SHALL have port out_valid  output  1  one-cycle pulse, word result valid.
REQ-012 SHALL have port pe  output  1  registered: accepted in_data had an even number of ones.
REQ-013 SHALL have port po  output  1  registered: accepted in_data had an odd number of ones.
REQ-014 SHALL have port word_err  output  1  registered per-word parity mismatch, qualified by out_valid.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse, frame check complete.
REQ-016 SHALL have port frame_err  output  1  registered column-parity mismatch, qualified by frame_done.
REQ-017 SHALL have port col_par  output  WIDTH  running column XOR of the current frame's non-last words.
REQ-018 SHALL have port err_count  output  CNT_W  saturating total of word and frame errors.
REQ-019 SHALL have port busy  output  1  high while in state FRAME.

Function
REQ-020 A word SHALL be accepted exactly when enable=1, in_valid=1 and clear=0.
REQ-021 For each accepted word, out_valid SHALL be 1 on the following cycle; otherwise out_valid SHALL be 0.
REQ-022 With out_valid=1, pe SHALL be ~^in_data and po SHALL be ^in_data of the accepted word.
REQ-023 With out_valid=1, word_err SHALL be (^{in_data,in_par}) != odd_sel.
REQ-024 The FSM SHALL have exactly two states, IDLE and FRAME, and SHALL enter IDLE on reset.
REQ-025 FSM transitions on an accepted non-last word:
- IDLE -> FRAME, with col_par <= in_data.
- FRAME -> FRAME, with col_par <= col_par ^ in_data.
REQ-026 FSM transitions on an accepted last word:
- from FRAME -> IDLE
- from IDLE (single-word frame) -> IDLE, using col_par as all zeros.
- col_par <= 0 in both cases.
REQ-027 For an accepted last word, frame_done SHALL be 1 on the following cycle, and frame_err SHALL be 1 iff (col_par ^ in_data) != 0.
REQ-028 frame_done SHALL be 0 in every cycle not covered by REQ-027; frame_err and word_err SHALL hold their last values when not qualified.
REQ-029 err_count SHALL increase by word_err + frame_err (0, 1 or 2) in the cycle those results register, saturating at 2^CNT_W-1, and SHALL never wrap.
REQ-030 With enable=0, all registers (state, col_par, err_count, pe, po, errors) SHALL hold, and out_valid and frame_done SHALL be 0.
REQ-031 busy SHALL equal (state == FRAME), registered.

Reset
REQ-032 With clear=1 at a clock edge, regardless of enable, the block SHALL enter IDLE and set col_par, err_count, pe, po, word_err, frame_err, out_valid, frame_done and busy to 0.
REQ-033 A clear mid-frame SHALL abort the frame with no frame_done pulse, and an input word presented in the same cycle as clear SHALL be discarded.

Verification
REQ-034 WIDTH=9, even mode: after clear, send 9'h000, in_par=0, last=1 -> next cycle out_valid=1, pe=1, po=0, word_err=0, frame_done=1, frame_err=0, err_count=0.
REQ-035 Send 9'h1FF, in_par=0, odd_sel=0, last=0 -> pe=0, po=1, word_err=1, err_count=1, busy=1, col_par=9'h1FF.
REQ-036 Send a frame of 9'h003, 9'h005, then last 9'h006, each with correct parity -> frame_err=0. Repeat with last 9'h007 and in_par=1 -> frame_err=1, word_err=0, err_count +1.
REQ-037 CNT_W=2: send 5 words with bad parity, then a last word with bad parity and bad column -> err_count 1,2,3,3,3,3, never 0.
REQ-038 Send 9'h003, 9'h005, then clear -> busy=0, col_par=0, no frame_done. Then send last 9'h000 -> frame_err=0.
REQ-039 Hold enable=0 with in_valid=1 for 3 cycles -> out_valid=0, frame_done=0, and all other outputs unchanged.
